// File: rtl/alu_regread_stage_pkg.sv
// Shared types for the ALU register-read stage: widths, uop payload, bypass source tags.
package alu_regread_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PRF_W = 6;
    localparam int unsigned IMM_W = 16;

    typedef logic [PRF_W-1:0] PRFNum;

    typedef struct packed {
        PRFNum             op0_paddr;
        PRFNum             op1_paddr;
        PRFNum             dst_paddr;
        logic              dst_we;
        logic [IMM_W-1:0]  imm;
        logic              use_imm;
    } UOPBundle;

    // Which path supplied an operand; kept for debug visibility only.
    typedef enum logic [2:0] {
        EX0 = 3'd0,
        EX1 = 3'd1,
        WB0 = 3'd2,
        WB1 = 3'd3,
        PRF = 3'd4,
        IMM = 3'd5
    } Bypass_Src;

    // Sign-extend the uop immediate to datapath width.
    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_operand_bypass.sv
// Combinational operand selector: immediate, EX/WB bypass by priority, else PRF data.
module alu_operand_bypass
    import alu_regread_stage_pkg::*;
(
    input  PRFNum               p,
    input  logic [XLEN-1:0]     prf_data,
    input  logic [XLEN-1:0]     ex_res_0,
    input  PRFNum               ex_dst_0,
    input  logic                ex_we_0,
    input  logic [XLEN-1:0]     ex_res_1,
    input  PRFNum               ex_dst_1,
    input  logic                ex_we_1,
    input  logic [XLEN-1:0]     wb_res_0,
    input  PRFNum               wb_dst_0,
    input  logic                wb_we_0,
    input  logic [XLEN-1:0]     wb_res_1,
    input  PRFNum               wb_dst_1,
    input  logic                wb_we_1,
    input  logic                use_imm,
    input  logic [IMM_W-1:0]    imm,
    output logic [XLEN-1:0]     operand_c,
    output Bypass_Src           src_c
);

    logic nz_c;

    // Register 0 is hardwired zero and must never pick up a bypass.
    assign nz_c = (p != PRFNum'(0));

    // Priority select: imm, EX lane 0, EX lane 1, WB lane 0, WB lane 1, PRF.
    always_comb begin
        operand_c = prf_data;
        src_c     = PRF;
        if (use_imm) begin
            operand_c = sext_imm(imm);
            src_c     = IMM;
        end else if (nz_c && ex_we_0 && (ex_dst_0 == p)) begin
            operand_c = ex_res_0;
            src_c     = EX0;
        end else if (nz_c && ex_we_1 && (ex_dst_1 == p)) begin
            operand_c = ex_res_1;
            src_c     = EX1;
        end else if (nz_c && wb_we_0 && (wb_dst_0 == p)) begin
            operand_c = wb_res_0;
            src_c     = WB0;
        end else if (nz_c && wb_we_1 && (wb_dst_1 == p)) begin
            operand_c = wb_res_1;
            src_c     = WB1;
        end
    end

endmodule

// File: rtl/alu_regread_stage.sv
// Two-lane register-read stage: R-stage latches issued uops and reads the PRF,
// operands are resolved through EX/WB bypass, E-stage hands them to the exus.
module alu_regread_stage
    import alu_regread_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                issue_en_0,
    input  UOPBundle            issue_info_0,
    input  logic                issue_en_1,
    input  UOPBundle            issue_info_1,
    output PRFNum               rf_raddr_l_0,
    output PRFNum               rf_raddr_r_0,
    output PRFNum               rf_raddr_l_1,
    output PRFNum               rf_raddr_r_1,
    input  logic [XLEN-1:0]     rf_rdata_l_0,
    input  logic [XLEN-1:0]     rf_rdata_r_0,
    input  logic [XLEN-1:0]     rf_rdata_l_1,
    input  logic [XLEN-1:0]     rf_rdata_r_1,
    input  logic [XLEN-1:0]     ex_res_0,
    input  PRFNum               ex_dst_0,
    input  logic                ex_we_0,
    input  logic [XLEN-1:0]     ex_res_1,
    input  PRFNum               ex_dst_1,
    input  logic                ex_we_1,
    input  logic [XLEN-1:0]     wb_res_0,
    input  PRFNum               wb_dst_0,
    input  logic                wb_we_0,
    input  logic [XLEN-1:0]     wb_res_1,
    input  PRFNum               wb_dst_1,
    input  logic                wb_we_1,
    output logic                exu_valid_0,
    output UOPBundle            exu_uop_0,
    output logic [XLEN-1:0]     exu_src_a_0,
    output logic [XLEN-1:0]     exu_src_b_0,
    output Bypass_Src           exu_byp_a_0,
    output Bypass_Src           exu_byp_b_0,
    output logic                exu_valid_1,
    output UOPBundle            exu_uop_1,
    output logic [XLEN-1:0]     exu_src_a_1,
    output logic [XLEN-1:0]     exu_src_b_1,
    output Bypass_Src           exu_byp_a_1,
    output Bypass_Src           exu_byp_b_1
);

    logic            r_valid_0, r_valid_1;
    UOPBundle        r_uop_0, r_uop_1;

    logic [XLEN-1:0] opnd_a_0_c, opnd_b_0_c, opnd_a_1_c, opnd_b_1_c;
    Bypass_Src       byp_a_0_c, byp_b_0_c, byp_a_1_c, byp_b_1_c;

    // PRF addresses come straight from the R-stage uop, valid or not.
    assign rf_raddr_l_0 = r_uop_0.op0_paddr;
    assign rf_raddr_r_0 = r_uop_0.op1_paddr;
    assign rf_raddr_l_1 = r_uop_1.op0_paddr;
    assign rf_raddr_r_1 = r_uop_1.op1_paddr;

    alu_operand_bypass u_byp_a_0 (
        .p(r_uop_0.op0_paddr), .prf_data(rf_rdata_l_0),
        .ex_res_0(ex_res_0), .ex_dst_0(ex_dst_0), .ex_we_0(ex_we_0),
        .ex_res_1(ex_res_1), .ex_dst_1(ex_dst_1), .ex_we_1(ex_we_1),
        .wb_res_0(wb_res_0), .wb_dst_0(wb_dst_0), .wb_we_0(wb_we_0),
        .wb_res_1(wb_res_1), .wb_dst_1(wb_dst_1), .wb_we_1(wb_we_1),
        .use_imm(1'b0), .imm('0),
        .operand_c(opnd_a_0_c), .src_c(byp_a_0_c)
    );

    alu_operand_bypass u_byp_b_0 (
        .p(r_uop_0.op1_paddr), .prf_data(rf_rdata_r_0),
        .ex_res_0(ex_res_0), .ex_dst_0(ex_dst_0), .ex_we_0(ex_we_0),
        .ex_res_1(ex_res_1), .ex_dst_1(ex_dst_1), .ex_we_1(ex_we_1),
        .wb_res_0(wb_res_0), .wb_dst_0(wb_dst_0), .wb_we_0(wb_we_0),
        .wb_res_1(wb_res_1), .wb_dst_1(wb_dst_1), .wb_we_1(wb_we_1),
        .use_imm(r_uop_0.use_imm), .imm(r_uop_0.imm),
        .operand_c(opnd_b_0_c), .src_c(byp_b_0_c)
    );

    alu_operand_bypass u_byp_a_1 (
        .p(r_uop_1.op0_paddr), .prf_data(rf_rdata_l_1),
        .ex_res_0(ex_res_0), .ex_dst_0(ex_dst_0), .ex_we_0(ex_we_0),
        .ex_res_1(ex_res_1), .ex_dst_1(ex_dst_1), .ex_we_1(ex_we_1),
        .wb_res_0(wb_res_0), .wb_dst_0(wb_dst_0), .wb_we_0(wb_we_0),
        .wb_res_1(wb_res_1), .wb_dst_1(wb_dst_1), .wb_we_1(wb_we_1),
        .use_imm(1'b0), .imm('0),
        .operand_c(opnd_a_1_c), .src_c(byp_a_1_c)
    );

    alu_operand_bypass u_byp_b_1 (
        .p(r_uop_1.op1_paddr), .prf_data(rf_rdata_r_1),
        .ex_res_0(ex_res_0), .ex_dst_0(ex_dst_0), .ex_we_0(ex_we_0),
        .ex_res_1(ex_res_1), .ex_dst_1(ex_dst_1), .ex_we_1(ex_we_1),
        .wb_res_0(wb_res_0), .wb_dst_0(wb_dst_0), .wb_we_0(wb_we_0),
        .wb_res_1(wb_res_1), .wb_dst_1(wb_dst_1), .wb_we_1(wb_we_1),
        .use_imm(r_uop_1.use_imm), .imm(r_uop_1.imm),
        .operand_c(opnd_b_1_c), .src_c(byp_b_1_c)
    );

    // R and E pipeline registers; flush kills valids only, payload keeps flowing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_0   <= 1'b0;
            r_valid_1   <= 1'b0;
            r_uop_0     <= '0;
            r_uop_1     <= '0;
            exu_valid_0 <= 1'b0;
            exu_valid_1 <= 1'b0;
            exu_uop_0   <= '0;
            exu_uop_1   <= '0;
            exu_src_a_0 <= '0;
            exu_src_b_0 <= '0;
            exu_src_a_1 <= '0;
            exu_src_b_1 <= '0;
            exu_byp_a_0 <= PRF;
            exu_byp_b_0 <= PRF;
            exu_byp_a_1 <= PRF;
            exu_byp_b_1 <= PRF;
        end else begin
            r_uop_0     <= issue_info_0;
            r_uop_1     <= issue_info_1;
            exu_uop_0   <= r_uop_0;
            exu_uop_1   <= r_uop_1;
            exu_src_a_0 <= opnd_a_0_c;
            exu_src_b_0 <= opnd_b_0_c;
            exu_src_a_1 <= opnd_a_1_c;
            exu_src_b_1 <= opnd_b_1_c;
            exu_byp_a_0 <= byp_a_0_c;
            exu_byp_b_0 <= byp_b_0_c;
            exu_byp_a_1 <= byp_a_1_c;
            exu_byp_b_1 <= byp_b_1_c;
            if (flush) begin
                r_valid_0   <= 1'b0;
                r_valid_1   <= 1'b0;
                exu_valid_0 <= 1'b0;
                exu_valid_1 <= 1'b0;
            end else begin
                r_valid_0   <= issue_en_0;
                r_valid_1   <= issue_en_1;
                exu_valid_0 <= r_valid_0;
                exu_valid_1 <= r_valid_1;
            end
        end
    end

endmodule

// File: tb/tb_alu_regread_stage.sv
// Bench for alu_regread_stage: directed scenarios plus a per-cycle reference model.
module tb_alu_regread_stage;
    import alu_regread_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              issue_en_0, issue_en_1;
    UOPBundle          issue_info_0, issue_info_1;
    PRFNum             rf_raddr_l_0, rf_raddr_r_0, rf_raddr_l_1, rf_raddr_r_1;
    logic [XLEN-1:0]   rf_rdata_l_0, rf_rdata_r_0, rf_rdata_l_1, rf_rdata_r_1;
    logic [XLEN-1:0]   ex_res_0, ex_res_1, wb_res_0, wb_res_1;
    PRFNum             ex_dst_0, ex_dst_1, wb_dst_0, wb_dst_1;
    logic              ex_we_0, ex_we_1, wb_we_0, wb_we_1;
    logic              exu_valid_0, exu_valid_1;
    UOPBundle          exu_uop_0, exu_uop_1;
    logic [XLEN-1:0]   exu_src_a_0, exu_src_b_0, exu_src_a_1, exu_src_b_1;
    Bypass_Src         exu_byp_a_0, exu_byp_b_0, exu_byp_a_1, exu_byp_b_1;

    logic [XLEN-1:0]   prf [64];

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    assign rf_rdata_l_0 = prf[rf_raddr_l_0];
    assign rf_rdata_r_0 = prf[rf_raddr_r_0];
    assign rf_rdata_l_1 = prf[rf_raddr_l_1];
    assign rf_rdata_r_1 = prf[rf_raddr_r_1];

    alu_regread_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_en_0(issue_en_0), .issue_info_0(issue_info_0),
        .issue_en_1(issue_en_1), .issue_info_1(issue_info_1),
        .rf_raddr_l_0(rf_raddr_l_0), .rf_raddr_r_0(rf_raddr_r_0),
        .rf_raddr_l_1(rf_raddr_l_1), .rf_raddr_r_1(rf_raddr_r_1),
        .rf_rdata_l_0(rf_rdata_l_0), .rf_rdata_r_0(rf_rdata_r_0),
        .rf_rdata_l_1(rf_rdata_l_1), .rf_rdata_r_1(rf_rdata_r_1),
        .ex_res_0(ex_res_0), .ex_dst_0(ex_dst_0), .ex_we_0(ex_we_0),
        .ex_res_1(ex_res_1), .ex_dst_1(ex_dst_1), .ex_we_1(ex_we_1),
        .wb_res_0(wb_res_0), .wb_dst_0(wb_dst_0), .wb_we_0(wb_we_0),
        .wb_res_1(wb_res_1), .wb_dst_1(wb_dst_1), .wb_we_1(wb_we_1),
        .exu_valid_0(exu_valid_0), .exu_uop_0(exu_uop_0),
        .exu_src_a_0(exu_src_a_0), .exu_src_b_0(exu_src_b_0),
        .exu_byp_a_0(exu_byp_a_0), .exu_byp_b_0(exu_byp_b_0),
        .exu_valid_1(exu_valid_1), .exu_uop_1(exu_uop_1),
        .exu_src_a_1(exu_src_a_1), .exu_src_b_1(exu_src_b_1),
        .exu_byp_a_1(exu_byp_a_1), .exu_byp_b_1(exu_byp_b_1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic UOPBundle mk(input int op0, input int op1, input int dst,
                                    input int imm, input bit use_imm);
        UOPBundle u;
        u.op0_paddr = PRFNum'(op0);
        u.op1_paddr = PRFNum'(op1);
        u.dst_paddr = PRFNum'(dst);
        u.dst_we    = 1'b1;
        u.imm       = 16'(imm);
        u.use_imm   = use_imm;
        return u;
    endfunction

    // Reference operand lookup: first matching producer in priority order, reg 0 never forwarded.
    function automatic logic [31:0] resolve(input PRFNum p);
        logic [31:0] res [4];
        PRFNum       dst [4];
        logic        we  [4];
        logic [31:0] v;
        res = '{ex_res_0, ex_res_1, wb_res_0, wb_res_1};
        dst = '{ex_dst_0, ex_dst_1, wb_dst_0, wb_dst_1};
        we  = '{ex_we_0, ex_we_1, wb_we_0, wb_we_1};
        v = prf[p];
        if (p != PRFNum'(0))
            for (int k = 3; k >= 0; k--)
                if (we[k] && dst[k] == p) v = res[k];
        return v;
    endfunction

    // Behavioural model: expected R-stage contents and E-stage outputs.
    logic        m_r_v [2] = '{1'b0, 1'b0};
    UOPBundle    m_r_u [2] = '{'0, '0};
    logic        m_e_v [2] = '{1'b0, 1'b0};
    UOPBundle    m_e_u [2] = '{'0, '0};
    logic [31:0] m_e_a [2] = '{32'd0, 32'd0};
    logic [31:0] m_e_b [2] = '{32'd0, 32'd0};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < 2; l++) begin
                m_r_v[l] <= 1'b0; m_r_u[l] <= '0;
                m_e_v[l] <= 1'b0; m_e_u[l] <= '0;
                m_e_a[l] <= '0;   m_e_b[l] <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                m_e_v[l] <= flush ? 1'b0 : m_r_v[l];
                m_e_u[l] <= m_r_u[l];
                m_e_a[l] <= resolve(m_r_u[l].op0_paddr);
                m_e_b[l] <= m_r_u[l].use_imm ? {{16{m_r_u[l].imm[15]}}, m_r_u[l].imm}
                                             : resolve(m_r_u[l].op1_paddr);
            end
            m_r_v[0] <= flush ? 1'b0 : issue_en_0;
            m_r_v[1] <= flush ? 1'b0 : issue_en_1;
            m_r_u[0] <= issue_info_0;
            m_r_u[1] <= issue_info_1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("m_valid_0", 64'(exu_valid_0), 64'(m_e_v[0]));
            chk("m_valid_1", 64'(exu_valid_1), 64'(m_e_v[1]));
            chk("m_raddr_l_0", 64'(rf_raddr_l_0), 64'(m_r_u[0].op0_paddr));
            chk("m_raddr_r_0", 64'(rf_raddr_r_0), 64'(m_r_u[0].op1_paddr));
            chk("m_raddr_l_1", 64'(rf_raddr_l_1), 64'(m_r_u[1].op0_paddr));
            chk("m_raddr_r_1", 64'(rf_raddr_r_1), 64'(m_r_u[1].op1_paddr));
            if (m_e_v[0]) begin
                chk("m_uop_0", 64'(exu_uop_0), 64'(m_e_u[0]));
                chk("m_src_a_0", 64'(exu_src_a_0), 64'(m_e_a[0]));
                chk("m_src_b_0", 64'(exu_src_b_0), 64'(m_e_b[0]));
            end
            if (m_e_v[1]) begin
                chk("m_uop_1", 64'(exu_uop_1), 64'(m_e_u[1]));
                chk("m_src_a_1", 64'(exu_src_a_1), 64'(m_e_a[1]));
                chk("m_src_b_1", 64'(exu_src_b_1), 64'(m_e_b[1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_byp();
        ex_we_0 = 0; ex_we_1 = 0; wb_we_0 = 0; wb_we_1 = 0;
        ex_dst_0 = '0; ex_dst_1 = '0; wb_dst_0 = '0; wb_dst_1 = '0;
        ex_res_0 = '0; ex_res_1 = '0; wb_res_0 = '0; wb_res_1 = '0;
    endtask

    initial begin
        int nt;
        int pulses;
        rst = 1'b0; flush = 1'b0;
        issue_en_0 = 0; issue_en_1 = 0;
        issue_info_0 = '0; issue_info_1 = '0;
        clr_byp();
        for (int i = 0; i < 64; i++) prf[i] = '0;
        tick(); tick();
        started = 1'b1;

        // Reset state
        chk("rst_valid_0", 64'(exu_valid_0), 64'd0);
        chk("rst_valid_1", 64'(exu_valid_1), 64'd0);
        chk("rst_src_a_0", 64'(exu_src_a_0), 64'd0);
        chk("rst_raddr_l_0", 64'(rf_raddr_l_0), 64'd0);
        rst = 1'b1;

        // Single issue, PRF operands, 2-cycle latency
        prf[5] = 32'h10; prf[6] = 32'h20;
        issue_en_0 = 1; issue_info_0 = mk(5, 6, 7, 0, 0);
        tick();
        chk("raddr_l_0", 64'(rf_raddr_l_0), 64'd5);
        chk("raddr_r_0", 64'(rf_raddr_r_0), 64'd6);
        chk("lat1_valid_0", 64'(exu_valid_0), 64'd0);
        issue_en_0 = 0;
        tick();
        chk("single_valid_0", 64'(exu_valid_0), 64'd1);
        chk("single_src_a", 64'(exu_src_a_0), 64'h10);
        chk("single_src_b", 64'(exu_src_b_0), 64'h20);
        chk("single_valid_1", 64'(exu_valid_1), 64'd0);

        // Asynchronous reset mid-stream
        issue_en_0 = 1;
        tick();
        issue_en_0 = 0;
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("arst_valid_0", 64'(exu_valid_0), 64'd0);
        chk("arst_src_a_0", 64'(exu_src_a_0), 64'd0);
        chk("arst_raddr_l_0", 64'(rf_raddr_l_0), 64'd0);
        tick();
        rst = 1'b1;

        // EX lane-0 bypass over stale PRF
        prf[9] = 32'h0;
        issue_en_0 = 1; issue_info_0 = mk(9, 6, 10, 0, 0);
        tick();
        issue_en_0 = 0;
        ex_we_0 = 1; ex_dst_0 = 9; ex_res_0 = 32'hAAAA;
        tick();
        chk("ex0_src_a", 64'(exu_src_a_0), 64'hAAAA);
        chk("ex0_byp_a", 64'(exu_byp_a_0), 64'(EX0));
        clr_byp();

        // Priority: EX lane 1 over WB lane 0, then WB lane 0 alone
        issue_en_0 = 1;
        tick();
        issue_en_0 = 0;
        ex_we_1 = 1; ex_dst_1 = 9; ex_res_1 = 32'h1111;
        wb_we_0 = 1; wb_dst_0 = 9; wb_res_0 = 32'h2222;
        tick();
        chk("prio_ex1", 64'(exu_src_a_0), 64'h1111);
        chk("prio_ex1_byp", 64'(exu_byp_a_0), 64'(EX1));
        issue_en_0 = 1;
        tick();
        issue_en_0 = 0;
        ex_we_1 = 0;
        tick();
        chk("prio_wb0", 64'(exu_src_a_0), 64'h2222);
        chk("prio_wb0_byp", 64'(exu_byp_a_0), 64'(WB0));
        clr_byp();

        // Both EX lanes match: lane 0 wins; lane-1 uop, both sources
        issue_en_1 = 1; issue_info_1 = mk(9, 9, 11, 0, 0);
        tick();
        issue_en_1 = 0;
        ex_we_0 = 1; ex_dst_0 = 9; ex_res_0 = 32'h3333;
        ex_we_1 = 1; ex_dst_1 = 9; ex_res_1 = 32'h4444;
        wb_we_1 = 1; wb_dst_1 = 9; wb_res_1 = 32'h5555;
        tick();
        chk("both_ex_a_1", 64'(exu_src_a_1), 64'h3333);
        chk("both_ex_b_1", 64'(exu_src_b_1), 64'h3333);
        clr_byp();

        // WB lane 1 alone
        prf[4] = 32'h44;
        issue_en_1 = 1; issue_info_1 = mk(4, 5, 12, 0, 0);
        tick();
        issue_en_1 = 0;
        wb_we_1 = 1; wb_dst_1 = 4; wb_res_1 = 32'h5555;
        tick();
        chk("wb1_src_a_1", 64'(exu_src_a_1), 64'h5555);
        chk("wb1_src_b_1", 64'(exu_src_b_1), 64'h10);
        clr_byp();

        // Register 0 never bypassed; sign-extended immediate
        prf[3] = 32'h33;
        issue_en_0 = 1; issue_info_0 = mk(0, 3, 13, 16'h8000, 1);
        tick();
        issue_en_0 = 0;
        ex_we_0 = 1; ex_dst_0 = 0; ex_res_0 = 32'hFFFF;
        ex_we_1 = 1; ex_dst_1 = 3; ex_res_1 = 32'h7777;
        tick();
        chk("zero_src_a", 64'(exu_src_a_0), 64'd0);
        chk("zero_byp_a", 64'(exu_byp_a_0), 64'(PRF));
        chk("imm_src_b", 64'(exu_src_b_0), 64'hFFFF8000);
        chk("imm_byp_b", 64'(exu_byp_b_0), 64'(IMM));
        clr_byp();

        // Flush one cycle after dual issue
        issue_en_0 = 1; issue_en_1 = 1;
        tick();
        issue_en_0 = 0; issue_en_1 = 0; flush = 1;
        tick();
        flush = 0;
        chk("flush_n1_valid_0", 64'(exu_valid_0), 64'd0);
        chk("flush_n1_valid_1", 64'(exu_valid_1), 64'd0);
        tick();
        chk("flush_n2_valid_0", 64'(exu_valid_0), 64'd0);
        chk("flush_n2_valid_1", 64'(exu_valid_1), 64'd0);

        // Issue in the flush cycle is dropped
        issue_en_0 = 1; flush = 1;
        tick();
        issue_en_0 = 0; flush = 0;
        tick();
        chk("drop_n1_valid_0", 64'(exu_valid_0), 64'd0);
        tick();
        chk("drop_n2_valid_0", 64'(exu_valid_0), 64'd0);

        // Back-to-back dual issue with random dependences
        for (int i = 1; i < 16; i++) prf[i] = $urandom;
        nt = 0; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                issue_en_0 = 1; issue_en_1 = 1;
                issue_info_0 = mk($urandom_range(0, 7), $urandom_range(0, 7), 1, 2 * i,
                                  1'($urandom_range(0, 1)));
                issue_info_1 = mk($urandom_range(0, 7), $urandom_range(0, 7), 2, 2 * i + 1,
                                  1'($urandom_range(0, 1)));
            end else begin
                issue_en_0 = 0; issue_en_1 = 0;
            end
            ex_we_0 = 1'($urandom_range(0, 1)); ex_dst_0 = PRFNum'($urandom_range(0, 7)); ex_res_0 = $urandom;
            ex_we_1 = 1'($urandom_range(0, 1)); ex_dst_1 = PRFNum'($urandom_range(0, 7)); ex_res_1 = $urandom;
            wb_we_0 = 1'($urandom_range(0, 1)); wb_dst_0 = PRFNum'($urandom_range(0, 7)); wb_res_0 = $urandom;
            wb_we_1 = 1'($urandom_range(0, 1)); wb_dst_1 = PRFNum'($urandom_range(0, 7)); wb_res_1 = $urandom;
            tick();
            if (exu_valid_0) begin
                chk("order_tag_0", 64'(exu_uop_0.imm), 64'(nt));
                nt++; pulses++;
            end
            if (exu_valid_1) begin
                chk("order_tag_1", 64'(exu_uop_1.imm), 64'(nt));
                nt++; pulses++;
            end
        end
        chk("pulse_count", 64'(pulses), 64'd20);
        clr_byp();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
